mxn_table_gen: RTL and testbench
================================

Name: mxn_table_gen

Overview:
Generates the precomputed multiple tables for a radix-2^PBITS Montgomery datapath:
- k*m (unreduced), for k = 0..MLSIZE-1
- k*b mod m, for k = 0..MLSIZE-1

Operands are latched on a start pulse. The block fills one table entry per cycle through a small FSM, then reports completion with a busy/done handshake. Tables are served through an indexed, registered read port rather than wide parallel arrays. It sits between operand load and the Montgomery multiplier core, which reads entries per digit.

Parameters:
- NBITS, 4096, operand/modulus width in bits
- PBITS, 2, radix bits per digit (PBITS >= 1)
- MLSIZE, 1 << PBITS, table depth (derived; must not be overridden)

Ports:
- clk, input, 1, single clock, rising edge
- rst_n, input, 1, reset, synchronous active-low
- start, input, 1, one-cycle pulse; latches m and b and begins a fill
- m, input, NBITS, modulus; sampled only when start=1; must be odd and nonzero
- b, input, NBITS, multiplicand; sampled only when start=1; caller guarantees b < m
- busy, output, 1, high while a fill is in progress
- done, output, 1, registered one-cycle pulse when a fill completes
- rd_idx, input, PBITS, table read index k
- mxn_rd, output, NBITS+PBITS, k*m; 1-cycle read latency
- bxn_rd, output, NBITS, k*b mod m; 1-cycle read latency

Behaviour:
Reset (rst_n=0 at a clock edge):
- State goes to IDLE.
- busy=0, done=0, mxn_rd=0, bxn_rd=0.
- Both tables and all accumulators are cleared to 0.
- Reset overrides start in the same cycle.

FSM states:
- IDLE:
  - start -> FILL, with k=1, m_q=m, b_q=b, acc_m=m, acc_b=b.
- FILL:
  - Each cycle writes mtab[k]=acc_m and btab[k]=acc_b.
  - Updates acc_m += m_q.
  - Updates acc_b = red(acc_b + b_q), where red(x) = (x >= m_q) ? x - m_q : x. This uses one conditional subtract on an NBITS+1-bit sum.
  - Then k += 1.
  - After the write at k = MLSIZE-1: -> IDLE, and done=1 on the next cycle.
- Entry 0 is never written. It always reads 0 for both tables.

Timing and handshake:
- Latency: start at cycle 0; writes at cycles 1..MLSIZE-1; done=1 at cycle MLSIZE, for exactly one cycle.
- busy=1 from cycle 1 through cycle MLSIZE-1 inclusive.
- start while busy: abort and restart with the new operands, same timing as from IDLE. The aborted fill produces no done. Entries written by the aborted run are overwritten by the new run.
- start in the same cycle as done=1: accepted; the new fill begins normally.

Read port:
- mxn_rd and bxn_rd are registered from rd_idx every cycle (1-cycle latency) regardless of state.
- Contents are guaranteed consistent only when busy=0 after done. During FILL, unwritten entries return their previous values.

Width rules:
- acc_m is NBITS+PBITS bits and never overflows, since (MLSIZE-1)*m < 2^(NBITS+PBITS).
- acc_b < m_q always holds, given b < m.
- Tables hold their values until the next start or reset.

Decomposition:
Shared package mxn_pkg contains:
- the FSM state enum (IDLE, FILL)
- localparams MLSIZE and the index/entry widths
- the table type definitions

Sub-module mod_add_red (a + b, then single conditional subtract of m, width NBITS) is reusable elsewhere in the Montgomery datapath.

Test Plan:
1. NBITS=8, PBITS=2, start with m=197, b=100 -> busy cycles 1-3, done pulse at cycle 4; reads k=1,2,3 give mxn 197/394/591 and bxn 100/3/103.
2. After test 1, rd_idx=0 -> mxn_rd=0, bxn_rd=0 one cycle later; rd_idx=2 -> 394/3 one cycle later.
3. Start (m=197, b=100) at cycle 0, then start (m=255, b=254) at cycle 2 -> single done at cycle 6; mxn 255/510/765, bxn 254/253/252.
4. Start at cycle 0, rst_n=0 at cycle 2 -> busy=0 and done=0 from cycle 3; all reads 0; no done ever.
5. b=0, m=9 -> all bxn entries 0, mxn 9/18/27. PBITS=3 with m=255, b=1 -> done at cycle 8, bxn[k]=k, mxn[7]=1785.
6. Restart on the done cycle of test 1 with m=255, b=254 -> second done exactly 4 cycles later; tables match the values in test 3.

Source files
------------

// File: rtl/mxn_pkg.sv
// mxn_pkg: shared definitions for the Montgomery multiple-table generator.
// Contents:
//   state_e      - fill controller states (IDLE, FILL)
//   DEF_*        - default operand/radix widths and the derived table geometry
//   *_entry_t    - table entry types for the default configuration
//   mlsize()     - table depth derived from the radix bit count
package mxn_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    FILL = 1'b1
  } state_e;

  localparam int unsigned DEF_NBITS  = 32'd4096;
  localparam int unsigned DEF_PBITS  = 32'd2;
  localparam int unsigned DEF_MLSIZE = 32'd1 << DEF_PBITS;
  localparam int unsigned DEF_IDX_W  = DEF_PBITS;
  localparam int unsigned DEF_MXN_W  = DEF_NBITS + DEF_PBITS;
  localparam int unsigned DEF_BXN_W  = DEF_NBITS;

  typedef logic [DEF_MXN_W-1:0] def_mxn_entry_t;
  typedef logic [DEF_BXN_W-1:0] def_bxn_entry_t;
  typedef def_mxn_entry_t def_mxn_tab_t [DEF_MLSIZE];
  typedef def_bxn_entry_t def_bxn_tab_t [DEF_MLSIZE];

  // Table depth for a radix-2^pbits digit.
  function automatic int unsigned mlsize(input int unsigned pbits);
    return 32'd1 << pbits;
  endfunction

endpackage

// File: rtl/mxn_table_gen_if.sv
// mxn_table_gen_if: operand load, handshake and table read bundle.
// Signals:
//   start  - one-cycle pulse latching m/b and starting a fill
//   m, b   - modulus and multiplicand (NBITS)
//   busy   - fill in progress
//   done   - one-cycle completion pulse
//   rd_idx - table read index (PBITS)
//   mxn_rd - k*m for the index presented one cycle earlier
//   bxn_rd - k*b mod m for the index presented one cycle earlier
// Modports: master drives start/m/b/rd_idx; slave is the table generator.
interface mxn_table_gen_if #(
  parameter int NBITS = 4096,
  parameter int PBITS = 2
) ();

  logic                   start;
  logic [NBITS-1:0]       m;
  logic [NBITS-1:0]       b;
  logic                   busy;
  logic                   done;
  logic [PBITS-1:0]       rd_idx;
  logic [NBITS+PBITS-1:0] mxn_rd;
  logic [NBITS-1:0]       bxn_rd;

  modport master (
    output start, m, b, rd_idx,
    input  busy, done, mxn_rd, bxn_rd
  );

  modport slave (
    input  start, m, b, rd_idx,
    output busy, done, mxn_rd, bxn_rd
  );

endinterface

// File: rtl/mod_add_red.sv
// mod_add_red: y = (a + b) reduced once by m.
// Ports:
//   a, b - addends, each < m (W bits)
//   m    - modulus (W bits)
//   y    - (a + b) mod m (W bits), combinational
// The sum is formed on W+1 bits so the carry takes part in the compare;
// with a, b < m a single conditional subtract is a full reduction.
module mod_add_red #(
  parameter int W = 4096
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [W-1:0] m,
  output logic [W-1:0] y
);

  logic [W:0] sum_s;

  // Wide add followed by one conditional subtract of the modulus.
  always_comb begin
    sum_s = {1'b0, a} + {1'b0, b};
    if (sum_s >= {1'b0, m}) begin
      y = W'(sum_s - {1'b0, m});
    end else begin
      y = sum_s[W-1:0];
    end
  end

endmodule

// File: rtl/mxn_table_gen.sv
// mxn_table_gen: fills k*m and k*b mod m tables (k = 0..MLSIZE-1), one
// entry per cycle after a start pulse, and serves them through a registered
// indexed read port.
// Ports:
//   clk   - rising-edge clock
//   rst_n - synchronous active-low reset (clears state, tables, outputs)
//   bus   - mxn_table_gen_if slave: start/m/b in, busy/done out,
//           rd_idx in, mxn_rd/bxn_rd out (1-cycle read latency)
// Entry 0 is never written, so it always reads as zero.
module mxn_table_gen
  import mxn_pkg::*;
#(
  parameter int NBITS = 4096,
  parameter int PBITS = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  mxn_table_gen_if.slave    bus
);

  localparam int MLSIZE = int'(mlsize(PBITS));
  localparam int MXN_W  = NBITS + PBITS;
  localparam logic [PBITS-1:0] LAST_K = PBITS'(MLSIZE - 1);

  typedef logic [MXN_W-1:0] mxn_entry_t;
  typedef logic [NBITS-1:0] bxn_entry_t;

  state_e           state_r, state_s;
  logic [PBITS-1:0] k_r, k_s;
  logic             load_s, wr_s, done_s;
  logic             busy_r, done_r;

  logic [NBITS-1:0] m_q_r, b_q_r, acc_b_r, acc_b_next_s;
  logic [MXN_W-1:0] acc_m_r;

  mxn_entry_t mtab_r [MLSIZE];
  bxn_entry_t btab_r [MLSIZE];
  mxn_entry_t mxn_rd_r;
  bxn_entry_t bxn_rd_r;

  // Next-state and control decode; start always (re)loads, even mid-fill.
  always_comb begin
    state_s = state_r;
    k_s     = k_r;
    load_s  = 1'b0;
    wr_s    = 1'b0;
    done_s  = 1'b0;
    if (bus.start) begin
      state_s = FILL;
      k_s     = PBITS'(1);
      load_s  = 1'b1;
    end else begin
      case (state_r)
        IDLE: begin
          state_s = IDLE;
        end
        FILL: begin
          wr_s = 1'b1;
          k_s  = k_r + PBITS'(1);
          if (k_r == LAST_K) begin
            state_s = IDLE;
            done_s  = 1'b1;
          end else begin
            state_s = FILL;
          end
        end
        default: begin
          state_s = IDLE;
        end
      endcase
    end
  end

  // Controller state, entry index and registered handshake outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r <= IDLE;
      k_r     <= '0;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      k_r     <= k_s;
      busy_r  <= (state_s == FILL);
      done_r  <= done_s;
    end
  end

  mod_add_red #(.W(NBITS)) u_red (
    .a (acc_b_r),
    .b (b_q_r),
    .m (m_q_r),
    .y (acc_b_next_s)
  );

  // Operand latches, running multiples and table writes.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      m_q_r   <= '0;
      b_q_r   <= '0;
      acc_m_r <= '0;
      acc_b_r <= '0;
      for (int i = 0; i < MLSIZE; i++) begin
        mtab_r[i] <= '0;
        btab_r[i] <= '0;
      end
    end else if (load_s) begin
      m_q_r   <= bus.m;
      b_q_r   <= bus.b;
      acc_m_r <= {{PBITS{1'b0}}, bus.m};
      acc_b_r <= bus.b;
    end else if (wr_s) begin
      mtab_r[k_r] <= acc_m_r;
      btab_r[k_r] <= acc_b_r;
      acc_m_r     <= acc_m_r + {{PBITS{1'b0}}, m_q_r};
      acc_b_r     <= acc_b_next_s;
    end
  end

  // Registered read port, updated every cycle regardless of fill state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mxn_rd_r <= '0;
      bxn_rd_r <= '0;
    end else begin
      mxn_rd_r <= mtab_r[bus.rd_idx];
      bxn_rd_r <= btab_r[bus.rd_idx];
    end
  end

  assign bus.busy   = busy_r;
  assign bus.done   = done_r;
  assign bus.mxn_rd = mxn_rd_r;
  assign bus.bxn_rd = bxn_rd_r;

endmodule

// File: tb/tb_mxn_table_gen.sv
// tb_mxn_table_gen: directed and randomized checks of mxn_table_gen for
// NBITS=8 with PBITS=2 (dut) and PBITS=3 (dut3). Expected table contents
// come from plain arithmetic: mxn[k] = k*m, bxn[k] = (k*b) % m.
module tb_mxn_table_gen;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mxn_table_gen_if #(.NBITS(8), .PBITS(2)) bus2 ();
  mxn_table_gen_if #(.NBITS(8), .PBITS(3)) bus3 ();

  mxn_table_gen #(.NBITS(8), .PBITS(2)) dut  (.clk(clk), .rst_n(rst_n), .bus(bus2));
  mxn_table_gen #(.NBITS(8), .PBITS(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  int total  = 0;
  int passed = 0;
  int failed = 0;

  logic [63:0] exp_mxn [8];
  logic [63:0] exp_bxn [8];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic set_model(input int depth, input longint m, input longint b);
    for (int k = 0; k < 8; k++) begin
      exp_mxn[k] = (k < depth) ? 64'(k * m) : 64'd0;
      exp_bxn[k] = (k < depth) ? 64'((k * b) % m) : 64'd0;
    end
  endtask

  // Called in the cycle where start is asserted; returns in the done cycle.
  task automatic run_fill2(input string tag, input int m, input int b);
    bus2.start = 1'b1;
    bus2.m = 8'(m);
    bus2.b = 8'(b);
    set_model(4, m, b);
    tick;
    bus2.start = 1'b0;
    for (int c = 1; c <= 3; c++) begin
      chk($sformatf("%s_busy_c%0d", tag, c), 64'(bus2.busy), 64'd1);
      chk($sformatf("%s_nodone_c%0d", tag, c), 64'(bus2.done), 64'd0);
      tick;
    end
    chk($sformatf("%s_done_c4", tag), 64'(bus2.done), 64'd1);
    chk($sformatf("%s_idle_c4", tag), 64'(bus2.busy), 64'd0);
  endtask

  task automatic read_all2(input string tag);
    for (int k = 0; k < 4; k++) begin
      bus2.rd_idx = 2'(k);
      tick;
      chk($sformatf("%s_mxn%0d", tag, k), 64'(bus2.mxn_rd), exp_mxn[k]);
      chk($sformatf("%s_bxn%0d", tag, k), 64'(bus2.bxn_rd), exp_bxn[k]);
    end
  endtask

  task automatic run_fill3(input string tag, input int m, input int b);
    bus3.start = 1'b1;
    bus3.m = 8'(m);
    bus3.b = 8'(b);
    set_model(8, m, b);
    tick;
    bus3.start = 1'b0;
    for (int c = 1; c <= 7; c++) begin
      chk($sformatf("%s_busy_c%0d", tag, c), 64'(bus3.busy), 64'd1);
      chk($sformatf("%s_nodone_c%0d", tag, c), 64'(bus3.done), 64'd0);
      tick;
    end
    chk($sformatf("%s_done_c8", tag), 64'(bus3.done), 64'd1);
    tick;
    chk($sformatf("%s_done_c9", tag), 64'(bus3.done), 64'd0);
    for (int k = 0; k < 8; k++) begin
      bus3.rd_idx = 3'(k);
      tick;
      chk($sformatf("%s_mxn%0d", tag, k), 64'(bus3.mxn_rd), exp_mxn[k]);
      chk($sformatf("%s_bxn%0d", tag, k), 64'(bus3.bxn_rd), exp_bxn[k]);
    end
  endtask

  initial begin
    int rm, rb;
    rst_n = 1'b0;
    bus2.start = 1'b0; bus2.m = 8'd0; bus2.b = 8'd0; bus2.rd_idx = 2'd0;
    bus3.start = 1'b0; bus3.m = 8'd0; bus3.b = 8'd0; bus3.rd_idx = 3'd0;
    // Start during reset must be ignored.
    tick;
    bus2.start = 1'b1; bus2.m = 8'd197; bus2.b = 8'd100;
    tick;
    bus2.start = 1'b0;
    tick;
    chk("rst_busy", 64'(bus2.busy), 64'd0);
    chk("rst_done", 64'(bus2.done), 64'd0);
    chk("rst_mxn", 64'(bus2.mxn_rd), 64'd0);
    chk("rst_bxn", 64'(bus2.bxn_rd), 64'd0);
    rst_n = 1'b1;
    tick;
    chk("post_rst_busy", 64'(bus2.busy), 64'd0);

    // Basic fill m=197, b=100, then done drops after one cycle.
    run_fill2("t1", 197, 100);
    tick;
    chk("t1_done_c5", 64'(bus2.done), 64'd0);
    read_all2("t1");
    bus2.rd_idx = 2'd2;
    tick;
    chk("t2_mxn2", 64'(bus2.mxn_rd), 64'd394);
    chk("t2_bxn2", 64'(bus2.bxn_rd), 64'd3);

    // Abort at cycle 2 and restart with new operands; single done at cycle 6.
    bus2.start = 1'b1; bus2.m = 8'd197; bus2.b = 8'd100;
    tick;
    bus2.start = 1'b0;
    chk("t3_busy_c1", 64'(bus2.busy), 64'd1);
    tick;
    chk("t3_nodone_c2", 64'(bus2.done), 64'd0);
    run_fill2("t3", 255, 254);
    tick;
    chk("t3_done_after", 64'(bus2.done), 64'd0);
    read_all2("t3");

    // Reset at cycle 2 of a fill: outputs clear, tables zero, no done.
    bus2.start = 1'b1; bus2.m = 8'd197; bus2.b = 8'd100;
    tick;
    bus2.start = 1'b0;
    tick;
    rst_n = 1'b0;
    tick;
    chk("t4_busy_c3", 64'(bus2.busy), 64'd0);
    chk("t4_done_c3", 64'(bus2.done), 64'd0);
    rst_n = 1'b1;
    for (int c = 0; c < 5; c++) begin
      tick;
      chk($sformatf("t4_nodone_%0d", c), 64'(bus2.done), 64'd0);
    end
    set_model(1, 1, 0);
    read_all2("t4");

    // b = 0 leaves every bxn entry at zero.
    run_fill2("t5", 9, 0);
    tick;
    read_all2("t5");

    // Restart on the done cycle: second done exactly 4 cycles later.
    run_fill2("t6a", 197, 100);
    run_fill2("t6b", 255, 254);
    tick;
    chk("t6_done_after", 64'(bus2.done), 64'd0);
    read_all2("t6");

    // Randomized fills against the arithmetic model.
    for (int i = 0; i < 8; i++) begin
      rm = int'($urandom_range(0, 127)) * 2 + 1;
      rb = int'($urandom_range(0, rm - 1));
      run_fill2($sformatf("r%0d", i), rm, rb);
      tick;
      read_all2($sformatf("r%0d", i));
    end

    // Eight-entry table.
    run_fill3("p3", 255, 1);
    chk("p3_mxn7_direct", exp_mxn[7], 64'd1785);
    for (int i = 0; i < 3; i++) begin
      rm = int'($urandom_range(0, 127)) * 2 + 1;
      rb = int'($urandom_range(0, rm - 1));
      run_fill3($sformatf("p3r%0d", i), rm, rb);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
